// File: rtl/mioc_gate_test_ctrl_if.sv
// Control/status bundle between the gate test sequencer and its environment.
interface mioc_gate_test_ctrl_if #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned ERR_W = 8
);

  logic              start;
  logic              abort;
  logic              z;
  logic [N_IN-1:0]   in_vec;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [N_IN-1:0]   fail_vec;
  logic              fail_seen;
  logic              sample_valid;
  logic              sample_z;

  // Environment side: issues commands, supplies the gate output, observes results.
  modport master (
    output start,
    output abort,
    output z,
    input  in_vec,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec,
    input  fail_seen,
    input  sample_valid,
    input  sample_z
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  abort,
    input  z,
    output in_vec,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec,
    output fail_seen,
    output sample_valid,
    output sample_z
  );

endinterface

// File: rtl/mioc_gate_test_ctrl.sv
// Exhaustive functional test sequencer for one MIOC MOS logic gate.
// Steps every input vector in ascending order, waits a settle time, samples
// the synchronized gate output and compares it against a truth table.
module mioc_gate_test_ctrl #(
  parameter int unsigned             N_IN   = 2,
  parameter int unsigned             SETTLE = 4,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b1001,
  parameter int unsigned             ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mioc_gate_test_ctrl_if.slave bus
);

  localparam int unsigned      NVEC      = 1 << N_IN;
  localparam int unsigned      CNT_W     = 8;
  localparam logic [N_IN-1:0]  LAST_VEC  = N_IN'(NVEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q,        state_d;
  logic [N_IN-1:0]    vec_q,          vec_d;
  logic [CNT_W-1:0]   cnt_q,          cnt_d;
  logic [N_IN-1:0]    in_vec_q,       in_vec_d;
  logic               busy_q,         busy_d;
  logic               done_q,         done_d;
  logic               pass_q,         pass_d;
  logic [ERR_W-1:0]   err_count_q,    err_count_d;
  logic [N_IN-1:0]    fail_vec_q,     fail_vec_d;
  logic               fail_seen_q,    fail_seen_d;
  logic               sample_valid_q, sample_valid_d;
  logic               sample_z_q,     sample_z_d;
  logic               z_s1_q,         z_s2_q;

  logic               mismatch_c;
  logic [ERR_W-1:0]   err_inc_c;

  // Two-flop synchronizer for the asynchronous gate output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_s1_q <= 1'b0;
      z_s2_q <= 1'b0;
    end else begin
      z_s1_q <= bus.z;
      z_s2_q <= z_s1_q;
    end
  end

  // sample_z holds the synchronized z captured on entry to SAMPLE, so the
  // reported value and the compared value are always the same bit.
  always_comb begin
    mismatch_c = (sample_z_q != TRUTH[vec_q]);
    err_inc_c  = (err_count_q == ERR_MAX) ? err_count_q
                                          : err_count_q + ERR_W'(1);
  end

  // Next-state and registered-output logic for the test sequencer.
  always_comb begin
    state_d        = state_q;
    vec_d          = vec_q;
    cnt_d          = cnt_q;
    in_vec_d       = in_vec_q;
    done_d         = done_q;
    pass_d         = pass_q;
    err_count_d    = err_count_q;
    fail_vec_d     = fail_vec_q;
    fail_seen_d    = fail_seen_q;
    sample_valid_d = 1'b0;
    sample_z_d     = sample_z_q;

    if (bus.abort && (state_q != S_IDLE)) begin
      // Abort keeps the error record for debug; only the run control clears.
      state_d  = S_IDLE;
      in_vec_d = '0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start && !bus.abort) begin
            state_d     = S_APPLY;
            vec_d       = '0;
            in_vec_d    = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_count_d = '0;
            fail_vec_d  = '0;
            fail_seen_d = 1'b0;
          end
        end

        S_APPLY: begin
          in_vec_d = vec_q;
          cnt_d    = SETTLE_M1;
          state_d  = S_WAIT;
        end

        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d        = S_SAMPLE;
            sample_valid_d = 1'b1;
            sample_z_d     = z_s2_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          if (mismatch_c) begin
            err_count_d = err_inc_c;
            if (!fail_seen_q) begin
              fail_vec_d  = vec_q;
              fail_seen_d = 1'b1;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            pass_d   = (err_count_d == '0);
            in_vec_d = '0;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            state_d = S_APPLY;
          end
        end

        default: begin
          state_d  = S_IDLE;
          in_vec_d = '0;
        end
      endcase
    end

    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_SAMPLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      vec_q          <= '0;
      cnt_q          <= '0;
      in_vec_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_count_q    <= '0;
      fail_vec_q     <= '0;
      fail_seen_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_z_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      cnt_q          <= cnt_d;
      in_vec_q       <= in_vec_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      err_count_q    <= err_count_d;
      fail_vec_q     <= fail_vec_d;
      fail_seen_q    <= fail_seen_d;
      sample_valid_q <= sample_valid_d;
      sample_z_q     <= sample_z_d;
    end
  end

  assign bus.in_vec       = in_vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.err_count    = err_count_q;
  assign bus.fail_vec     = fail_vec_q;
  assign bus.fail_seen    = fail_seen_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_z     = sample_z_q;

endmodule

// File: tb/tb_mioc_gate_test_ctrl.sv
// Scoreboard bench for the gate test sequencer: a random gate truth function
// drives z, expected samples/results are queued at start, a monitor checks.
module tb_mioc_gate_test_ctrl;

  localparam int unsigned N_IN    = 2;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned NVEC    = 4;
  localparam int unsigned ERR_MAX = 3;
  localparam int unsigned RUN_CYC = NVEC * (SETTLE + 2);
  localparam logic [3:0]  TRUTH   = 4'b1001;

  typedef struct {
    logic [1:0] vec;
    logic       z;
  } samp_t;

  typedef struct {
    int         err;
    logic [1:0] fvec;
    logic       fseen;
    logic       pass;
    int         done_cyc;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gate_tt = 4'b1001;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       done_prev = 1'b0;
  samp_t      samp_q[$];
  res_t       res_q[$];
  samp_t      ms;
  res_t       mr;
  res_t       last_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mioc_gate_test_ctrl_if #(.N_IN(N_IN), .ERR_W(ERR_W)) bus ();

  mioc_gate_test_ctrl #(
    .N_IN(N_IN), .SETTLE(SETTLE), .TRUTH(TRUTH), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Gate under test: arbitrary truth function of the driven vector.
  assign bus.z = gate_tt[bus.in_vec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Expected record after the first k vectors of a run with gate function g.
  function automatic res_t model(input logic [3:0] g, input int k, input int scyc);
    res_t       r;
    int         mm = 0;
    logic [3:0] tt = TRUTH;
    r.fvec  = 2'b00;
    r.fseen = 1'b0;
    for (int v = 0; v < k; v++) begin
      if (g[v] != tt[v]) begin
        if (!r.fseen) begin
          r.fvec  = 2'(v);
          r.fseen = 1'b1;
        end
        mm++;
      end
    end
    r.err      = (mm > int'(ERR_MAX)) ? int'(ERR_MAX) : mm;
    r.pass     = (mm == 0);
    r.done_cyc = scyc + 1 + int'(RUN_CYC);
    return r;
  endfunction

  // Monitor: compares every sample pulse and every done rise against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (bus.sample_valid) begin
        if (samp_q.size() == 0) begin
          fail_now("unexpected_sample_valid");
        end else begin
          ms = samp_q.pop_front();
          check("sample_in_vec", 32'(bus.in_vec), 32'(ms.vec));
          check("sample_z", 32'(bus.sample_z), 32'(ms.z));
          check("busy_in_sample", 32'(bus.busy), 32'd1);
        end
      end
      if (bus.done && !done_prev) begin
        if (res_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mr = res_q.pop_front();
          check("done_err_count", 32'(bus.err_count), 32'(mr.err));
          check("done_fail_vec", 32'(bus.fail_vec), 32'(mr.fvec));
          check("done_fail_seen", 32'(bus.fail_seen), 32'(mr.fseen));
          check("done_pass", 32'(bus.pass), 32'(mr.pass));
          check("done_cycle", 32'(cyc), 32'(mr.done_cyc));
          check("done_in_vec", 32'(bus.in_vec), 32'd0);
          check("done_busy", 32'(bus.busy), 32'd0);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_vec"}, 32'(bus.in_vec), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    check({tag, "_fail_vec"}, 32'(bus.fail_vec), 32'd0);
    check({tag, "_fail_seen"}, 32'(bus.fail_seen), 32'd0);
    check({tag, "_sample_valid"}, 32'(bus.sample_valid), 32'd0);
    check({tag, "_sample_z"}, 32'(bus.sample_z), 32'd0);
  endtask

  // Start a run and queue its expected samples and final result.
  task automatic do_start(input logic [3:0] g);
    logic [3:0] gg;
    @(posedge clk); #1;
    gate_tt = g;
    gg = g;
    bus.start = 1'b1;
    for (int v = 0; v < int'(NVEC); v++) samp_q.push_back('{vec: 2'(v), z: gg[v]});
    last_res = model(g, NVEC, cyc);
    res_q.push_back(last_res);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_vec(input logic [1:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.busy && bus.in_vec == v) begin
        ok = 1'b1;
        return;
      end
    end
    fail_now("timeout_waiting_for_vector");
  endtask

  task automatic wait_results();
    for (int i = 0; i < int'(RUN_CYC) + 50; i++) begin
      @(posedge clk); #1;
      if (res_q.size() == 0 && samp_q.size() == 0) return;
    end
    fail_now("timeout_waiting_for_done");
    samp_q.delete();
    res_q.delete();
  endtask

  task automatic run_full(input logic [3:0] g, input bit extra_start);
    bit ok;
    do_start(g);
    if (extra_start) begin
      wait_vec(2'd1, ok);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    wait_results();
    check("done_persists", 32'(bus.done), 32'd1);
  endtask

  task automatic run_abort(input logic [3:0] g, input int k, input int j);
    bit   ok;
    res_t r;
    do_start(g);
    wait_vec(2'(k), ok);
    repeat (j) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    r = model(g, k, 0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_pass", 32'(bus.pass), 32'd0);
    check("abort_in_vec", 32'(bus.in_vec), 32'd0);
    check("abort_sample_valid", 32'(bus.sample_valid), 32'd0);
    check("abort_err_hold", 32'(bus.err_count), 32'(r.err));
    check("abort_fvec_hold", 32'(bus.fail_vec), 32'(r.fvec));
    check("abort_fseen_hold", 32'(bus.fail_seen), 32'(r.fseen));
    check("abort_samples_left", 32'(samp_q.size()), 32'(int'(NVEC) - k));
    samp_q.delete();
    res_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int mode;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // start together with abort in IDLE: nothing happens
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_start_abort_busy", 32'(bus.busy), 32'd0);

    // ideal XNOR, stuck-at-0, XOR (saturating count)
    run_full(4'b1001, 1'b0);
    run_full(4'b0000, 1'b0);
    run_full(4'b0110, 1'b0);

    // abort in WAIT of vector 2 then a clean run
    run_abort(4'b1001, 2, 1);
    run_full(4'b1001, 1'b0);

    // start while busy is ignored
    run_full(4'b1001, 1'b1);

    // start with abort in DONE: to IDLE, no new run, record held
    run_full(4'b0111, 1'b0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("done_abort_done", 32'(bus.done), 32'd0);
    check("done_abort_busy", 32'(bus.busy), 32'd0);
    check("done_abort_err_hold", 32'(bus.err_count), 32'(last_res.err));
    check("done_abort_fvec_hold", 32'(bus.fail_vec), 32'(last_res.fvec));
    repeat (4) @(posedge clk);
    #1 check("done_abort_no_run", 32'(bus.busy), 32'd0);

    // asynchronous reset in SAMPLE of vector 2
    do_start(4'b0110);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sample_valid && bus.in_vec == 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("timeout_waiting_for_sample");
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    samp_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_full(4'b1001, 1'b0);

    // randomized runs
    for (int it = 0; it < 24; it++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 2)
        run_abort(4'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, SETTLE - 1)));
      else
        run_full(4'($urandom), mode == 1);
    end

    repeat (3) @(posedge clk);
    if (samp_q.size() != 0 || res_q.size() != 0) fail_now("leftover_expectations");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
